// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: takes one EXU result at a time, runs a single memory access and hands the result to WBU.
// Optional build macro YSYX_25020047_LSU_ALIGN_CHK_EN rejects misaligned word accesses instead of issuing them.
module ysyx_25020047_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_read,
    input  logic        in_write,
    input  logic        in_reg_wen,
    input  logic        in_byte,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_wen,
    output logic        out_err
);
    // state | meaning
    // IDLE  | waiting for an EXU result
    // REQ   | memory request presented, waiting for mem_req_ready
    // WAIT  | request accepted, waiting for response or timeout
    // DONE  | result presented to WBU, waiting for out_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // WAIT counter counts down from TIMEOUT-1; terminal count 0 means the last allowed cycle
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        reg_wen_q, reg_wen_d;
    logic        byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_wen_q, out_wen_d;
    logic        out_err_q, out_err_d;
    logic        misaligned;
    logic [7:0]  rd_byte;

`ifdef YSYX_25020047_LSU_ALIGN_CHK_EN
    assign misaligned = ~in_byte & (in_read ^ in_write) & (in_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            2'd3:    rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        read_d     = read_q;
        write_d    = write_q;
        reg_wen_d  = reg_wen_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_wen_d  = out_wen_q;
        out_err_d  = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d    = in_addr;
                    wdata_d   = in_wdata;
                    read_d    = in_read;
                    write_d   = in_write;
                    reg_wen_d = in_reg_wen;
                    byte_d    = in_byte;
                    out_err_d = 1'b0;
                    if ((in_read & in_write) | misaligned) begin
                        out_data_d = 32'h0;
                        out_wen_d  = 1'b0;
                        out_err_d  = 1'b1;
                        state_d    = DONE;
                    end else if (in_read | in_write) begin
                        state_d = REQ;
                    end else begin
                        out_data_d = in_addr;
                        out_wen_d  = in_reg_wen;
                        state_d    = DONE;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = TO_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    if (read_q) out_data_d = byte_q ? {24'h0, rd_byte} : mem_rdata;
                    else        out_data_d = 32'h0;
                    out_wen_d = reg_wen_q & read_q;
                    state_d   = DONE;
                end else if (cnt_q == 16'h0) begin
                    out_wen_d = 1'b0;
                    out_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 16'h1;
                end
            end
            default: begin
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            reg_wen_q  <= 1'b0;
            byte_q     <= 1'b0;
            cnt_q      <= 16'h0;
            out_data_q <= 32'h0;
            out_wen_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            read_q     <= read_d;
            write_q    <= write_d;
            reg_wen_q  <= reg_wen_d;
            byte_q     <= byte_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_wen_q  <= out_wen_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign out_valid     = (state_q == DONE);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = write_q;
    assign mem_wdata     = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    assign mem_wmask     = !write_q ? 4'h0 : (byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF);
    assign out_data      = out_data_q;
    assign out_wen       = out_wen_q;
    assign out_err       = out_err_q;
endmodule
